sram_port_if: RTL and testbench
===============================

# sram_port_if

Per-port request adapter that sits directly upstream of the ZBT SRAM controller's mbs request ports. One instance per port (mbs0..mbs3). It converts a client valid/ready request stream into the controller's unacknowledged, time-slotted request interface, and turns the controller's stretched response-valid into a single-cycle response strobe. Each request is presented for a full slot rotation, so exactly one slot captures it. Reads are strictly one-outstanding and ordered with writes.

## Interface
Parameters:
- FIFO_DEPTH, 4: request FIFO entries; power of two, ≥2.
- HOLD_CYCLES, 4: cycles each request is held valid toward the controller; must equal the slot rotation period.
- RD_TIMEOUT, 32: read watchdog limit in cycles; used only with SRAM_PORT_TIMEOUT_EN.

Ports:
- clk_sram  in  1  sole clock.
- rst_sram  in  1  reset; synchronous, active-high.
- i_req_valid  in  1  client request valid.
- o_req_ready  out  1  FIFO not full.
- i_req_adr  in  18  byte address; the controller drops bits [1:0].
- i_req_we  in  1  1 = write, 0 = read.
- i_req_wdata  in  32  write data.
- i_req_be  in  4  byte enables.
- o_rsp_valid  out  1  one-cycle read response strobe.
- o_rsp_rdata  out  32  read data, valid with o_rsp_valid.
- o_rsp_err  out  1  response produced by timeout; valid with o_rsp_valid.
- o_mbs_req_adr / _we / _wdata / _be  out  18/1/32/4  request fields to the controller.
- o_mbs_req_valid  out  1  request valid to the controller.
- i_mbs_resp_rdata  in  32  controller read data.
- i_mbs_resp_valid  in  1  controller response valid; stretched, possibly merged.

## Operation
- FIFO push on i_req_valid & o_req_ready. o_req_ready = !full and does not depend on FSM state. Push and pop in the same cycle are legal.
- FSM states are IDLE, WR_HOLD, RD_HOLD, RD_WAIT, RD_DRAIN.
- IDLE:
  - Pops the head when the FIFO is non-empty.
  - A head read pops only if i_mbs_resp_valid = 0; a stale or late response blocks it.
  - Loads the o_mbs_req_* registers, sets o_mbs_req_valid = 1 and clears the hold counter.
- WR_HOLD / RD_HOLD:
  - Fields and valid stay stable for exactly HOLD_CYCLES cycles.
  - After that, o_mbs_req_valid = 0 and the FSM moves to IDLE (write) or RD_WAIT (read).
- RD_WAIT:
  - On i_mbs_resp_valid = 1, register i_mbs_resp_rdata into o_rsp_rdata, pulse o_rsp_valid, set o_rsp_err = 0, and go to RD_DRAIN.
  - No further FIFO pops occur here; writes never bypass a pending read.
- RD_DRAIN: wait until i_mbs_resp_valid = 0, then go to IDLE.
- Fields are not cleared when valid drops. They keep their last values.

## Timing
- Reset values: all outputs 0, FIFO empty, FSM in IDLE, counters 0. o_req_ready rises the cycle after reset deasserts.
- Pop to o_mbs_req_valid high: 1 cycle. Valid stays high for HOLD_CYCLES cycles.
- Back-to-back writes: one every HOLD_CYCLES+1 cycles, because IDLE costs a gap cycle.
- Rising edge of i_mbs_resp_valid to o_rsp_valid: 1 cycle.
- o_rsp_valid is high for exactly one cycle per read.
- Reset mid-operation:
  - Next edge clears the FIFO, FSM and outputs. In-flight requests are lost.
  - A controller response arriving after reset is absorbed by the IDLE read gate. It is never reported.
- Full FIFO: ready is low and no push occurs. Empty FIFO: the FSM idles with valid low.

## Configuration
- SRAM_PORT_TIMEOUT_EN defined:
  - RD_WAIT counts cycles from entry.
  - If the count reaches RD_TIMEOUT with no response, pulse o_rsp_valid with o_rsp_rdata = 32'h0 and o_rsp_err = 1, then go to RD_DRAIN.
  - A response in the same cycle as the timeout wins, with err = 0.
- Undefined: no counter. RD_WAIT waits indefinitely and o_rsp_err is tied to 0.

## Structure
- Package sram_port_pkg holds:
  - the FSM state enum (3-bit encoding);
  - the request struct {adr, we, wdata, be}, 55 bits;
  - the timeout data constant 32'h0.
- Sub-module sram_port_fifo is a synchronous FIFO of FIFO_DEPTH × 55 bits with full/empty flags and pointers wrapping at FIFO_DEPTH.

## Test plan
- Single write adr=18'h00104, wdata=32'hA5A5_5A5A, be=4'hF → o_mbs_req_valid high 4 cycles with stable fields; no o_rsp_valid.
- Read adr=18'h00040 with a model returning 32'hCAFE_F00D after 9 cycles, valid stretched 4 cycles → one o_rsp_valid pulse with rdata CAFE_F00D and err 0.
- Push 4 writes, then a 5th → ready low after the 4th, the 5th is stalled; the writes issue every 5 cycles in order.
- Read followed by a write → the write is not presented until after the read response and the drain.
- Reset asserted during RD_HOLD, then a late response → no o_rsp_valid. The next read waits for resp_valid low, then completes normally.
- With SRAM_PORT_TIMEOUT_EN and a model that never responds → o_rsp_valid at cycle 32 of RD_WAIT with rdata 0 and err 1; the next request then proceeds.

Source files
------------

// File: rtl/sram_port_pkg.sv
// Shared types and constants for the per-port SRAM request adapter.
package sram_port_pkg;

  localparam int ADR_W  = 18;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  // Adapter sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_HOLD  = 3'd1,
    ST_RD_HOLD  = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RD_DRAIN = 3'd4
  } state_e;

  // One client request as stored in the FIFO and presented to the controller.
  typedef struct packed {
    logic [ADR_W-1:0]  adr;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } sram_req_t;

  localparam int REQ_W = $bits(sram_req_t);

  // Read data returned when a read is abandoned by the watchdog.
  localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 32'h0;

endpackage

// File: rtl/sram_port_fifo.sv
// Synchronous request FIFO with full/empty flags. DEPTH must be a power of
// two; pointers carry one extra wrap bit to tell full from empty.
module sram_port_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 55
) (
  input  logic             clk_sram,
  input  logic             rst_sram,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q[PTR_W-1:0]];

  // Pointer advance on accepted push/pop.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
    if (do_pop)  rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk_sram) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst_sram) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage, written at the tail on push.
  always_ff @(posedge clk_sram) begin
    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/sram_port_if.sv
// Per-port request adapter in front of the ZBT SRAM controller's mbs ports.
// Client valid/ready requests are queued, then each one is held toward the
// controller for a full slot rotation. Reads are one-outstanding and ordered
// with writes; the stretched controller response becomes a one-cycle strobe.
// Optional read watchdog: define SRAM_PORT_TIMEOUT_EN.
module sram_port_if #(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int RD_TIMEOUT  = 32
) (
  input  logic        clk_sram,
  input  logic        rst_sram,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [17:0] i_req_adr,
  input  logic        i_req_we,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_be,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic [17:0] o_mbs_req_adr,
  output logic        o_mbs_req_we,
  output logic [31:0] o_mbs_req_wdata,
  output logic [3:0]  o_mbs_req_be,
  output logic        o_mbs_req_valid,
  input  logic [31:0] i_mbs_resp_rdata,
  input  logic        i_mbs_resp_valid
);

  import sram_port_pkg::*;

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int TO_W   = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

  // Reject configurations the slot timing and FIFO pointers cannot support.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      HOLD_CYCLES < 1 || RD_TIMEOUT < 1) begin : g_bad_param
    $error("sram_port_if: illegal parameter combination");
  end

  state_e             state_q, state_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  sram_req_t          mbs_req_q, mbs_req_d;
  logic               mbs_valid_q, mbs_valid_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               ready_en_q, ready_en_d;

  sram_req_t          push_req;
  logic [REQ_W-1:0]   fifo_dout;
  sram_req_t          head;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;

`ifdef SRAM_PORT_TIMEOUT_EN
  logic               rsp_err_q, rsp_err_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
`endif

  // Ready is held low through reset and rises one cycle after it releases;
  // afterwards it tracks only FIFO space, never the sequencer.
  assign ready_en_d  = 1'b1;
  assign o_req_ready = ready_en_q && !fifo_full;
  assign fifo_push   = i_req_valid && o_req_ready;
  assign push_req    = '{adr: i_req_adr, we: i_req_we, wdata: i_req_wdata, be: i_req_be};
  assign head        = fifo_dout;

  sram_port_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .clk_sram  (clk_sram),
    .rst_sram  (rst_sram),
    .push      (fifo_push),
    .push_data (push_req),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Sequencer: issue, hold for one slot rotation, then await/drain reads.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    mbs_req_d   = mbs_req_q;
    mbs_valid_d = mbs_valid_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    fifo_pop    = 1'b0;
`ifdef SRAM_PORT_TIMEOUT_EN
    rsp_err_d   = rsp_err_q;
    to_cnt_d    = to_cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        // A read waits out any lingering response so it cannot be mistaken
        // for its own answer.
        if (!fifo_empty && (head.we || !i_mbs_resp_valid)) begin
          fifo_pop    = 1'b1;
          mbs_req_d   = head;
          mbs_valid_d = 1'b1;
          hold_cnt_d  = '0;
          state_d     = head.we ? ST_WR_HOLD : ST_RD_HOLD;
        end
      end
      ST_WR_HOLD, ST_RD_HOLD: begin
        if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          mbs_valid_d = 1'b0;
          state_d     = (state_q == ST_WR_HOLD) ? ST_IDLE : ST_RD_WAIT;
`ifdef SRAM_PORT_TIMEOUT_EN
          to_cnt_d    = '0;
`endif
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_RD_WAIT: begin
        // A real response beats a watchdog expiry in the same cycle.
        if (i_mbs_resp_valid) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = i_mbs_resp_rdata;
`ifdef SRAM_PORT_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
          state_d     = ST_RD_DRAIN;
        end
`ifdef SRAM_PORT_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(RD_TIMEOUT - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = TIMEOUT_RDATA;
          rsp_err_d   = 1'b1;
          state_d     = ST_RD_DRAIN;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      ST_RD_DRAIN: begin
        if (!i_mbs_resp_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer and output registers.
  always_ff @(posedge clk_sram) begin
    if (rst_sram) begin
      state_q     <= ST_IDLE;
      hold_cnt_q  <= '0;
      mbs_req_q   <= '0;
      mbs_valid_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      mbs_req_q   <= mbs_req_d;
      mbs_valid_q <= mbs_valid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      ready_en_q  <= ready_en_d;
    end
  end

`ifdef SRAM_PORT_TIMEOUT_EN
  // Watchdog counter and error flag.
  always_ff @(posedge clk_sram) begin
    if (rst_sram) begin
      rsp_err_q <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      rsp_err_q <= rsp_err_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  assign o_rsp_err = rsp_err_q;
`else
  assign o_rsp_err = 1'b0;
`endif

  assign o_mbs_req_adr   = mbs_req_q.adr;
  assign o_mbs_req_we    = mbs_req_q.we;
  assign o_mbs_req_wdata = mbs_req_q.wdata;
  assign o_mbs_req_be    = mbs_req_q.be;
  assign o_mbs_req_valid = mbs_valid_q;
  assign o_rsp_valid     = rsp_valid_q;
  assign o_rsp_rdata     = rsp_rdata_q;

endmodule

// File: tb/tb_sram_port_if.sv
// Directed self-checking bench for sram_port_if (HOLD_CYCLES=4, FIFO_DEPTH=4).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_sram_port_if;

  logic        clk_sram = 1'b0;
  logic        rst_sram = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [17:0] i_req_adr = '0;
  logic        i_req_we = 1'b0;
  logic [31:0] i_req_wdata = '0;
  logic [3:0]  i_req_be = '0;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [17:0] o_mbs_req_adr;
  logic        o_mbs_req_we;
  logic [31:0] o_mbs_req_wdata;
  logic [3:0]  o_mbs_req_be;
  logic        o_mbs_req_valid;
  logic [31:0] i_mbs_resp_rdata = '0;
  logic        i_mbs_resp_valid = 1'b0;

  int checks   = 0;
  int failures = 0;

  sram_port_if #(
    .FIFO_DEPTH  (4),
    .HOLD_CYCLES (4),
    .RD_TIMEOUT  (32)
  ) dut (
    .clk_sram         (clk_sram),
    .rst_sram         (rst_sram),
    .i_req_valid      (i_req_valid),
    .o_req_ready      (o_req_ready),
    .i_req_adr        (i_req_adr),
    .i_req_we         (i_req_we),
    .i_req_wdata      (i_req_wdata),
    .i_req_be         (i_req_be),
    .o_rsp_valid      (o_rsp_valid),
    .o_rsp_rdata      (o_rsp_rdata),
    .o_rsp_err        (o_rsp_err),
    .o_mbs_req_adr    (o_mbs_req_adr),
    .o_mbs_req_we     (o_mbs_req_we),
    .o_mbs_req_wdata  (o_mbs_req_wdata),
    .o_mbs_req_be     (o_mbs_req_be),
    .o_mbs_req_valid  (o_mbs_req_valid),
    .i_mbs_resp_rdata (i_mbs_resp_rdata),
    .i_mbs_resp_valid (i_mbs_resp_valid)
  );

  always #5 clk_sram = ~clk_sram;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_sram);
    #1;
  endtask

  task automatic drive_req(input logic [17:0] adr, input logic we,
                           input logic [31:0] wdata, input logic [3:0] be);
    i_req_valid = 1'b1;
    i_req_adr   = adr;
    i_req_we    = we;
    i_req_wdata = wdata;
    i_req_be    = be;
  endtask

  task automatic test_reset();
    rst_sram = 1'b1;
    tick();
    tick();
    checks++;
    if (o_req_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready: got %b expected 0", o_req_ready);
    end
    checks++;
    if ({o_mbs_req_valid, o_rsp_valid, o_rsp_err, o_rsp_rdata} !== 35'h0) begin
      failures++; $display("FAIL reset_valids: got %h expected 0", {o_mbs_req_valid, o_rsp_valid, o_rsp_err, o_rsp_rdata});
    end
    checks++;
    if ({o_mbs_req_adr, o_mbs_req_we, o_mbs_req_wdata, o_mbs_req_be} !== 55'h0) begin
      failures++; $display("FAIL reset_fields: got %h expected 0", {o_mbs_req_adr, o_mbs_req_we, o_mbs_req_wdata, o_mbs_req_be});
    end
    rst_sram = 1'b0;
    checks++;
    if (o_req_ready !== 1'b0) begin
      failures++; $display("FAIL ready_at_release: got %b expected 0", o_req_ready);
    end
    tick();
    checks++;
    if (o_req_ready !== 1'b1) begin
      failures++; $display("FAIL ready_after_release: got %b expected 1", o_req_ready);
    end
    tick();
    checks++;
    if (o_mbs_req_valid !== 1'b0) begin
      failures++; $display("FAIL empty_idle_valid: got %b expected 0", o_mbs_req_valid);
    end
  endtask

  task automatic test_single_write();
    int first = -1;
    int hi = 0;
    int rsp = 0;
    int bad = 0;
    drive_req(18'h00104, 1'b1, 32'hA5A5_5A5A, 4'hF);
    tick();
    i_req_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (o_mbs_req_valid) begin
        if (first < 0) first = i;
        hi++;
        if ({o_mbs_req_adr, o_mbs_req_we, o_mbs_req_wdata, o_mbs_req_be} !==
            {18'h00104, 1'b1, 32'hA5A5_5A5A, 4'hF}) bad++;
      end
      if (o_rsp_valid) rsp++;
    end
    checks++;
    if (first !== 0) begin
      failures++; $display("FAIL wr_latency: got %0d expected 0", first);
    end
    checks++;
    if (hi !== 4) begin
      failures++; $display("FAIL wr_hold_cycles: got %0d expected 4", hi);
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL wr_fields_stable: got %0d bad cycles expected 0", bad);
    end
    checks++;
    if (rsp !== 0) begin
      failures++; $display("FAIL wr_no_rsp: got %0d pulses expected 0", rsp);
    end
    checks++;
    if ({o_mbs_req_valid, o_mbs_req_adr, o_mbs_req_wdata} !== {1'b0, 18'h00104, 32'hA5A5_5A5A}) begin
      failures++; $display("FAIL wr_fields_kept: got %h expected %h",
                           {o_mbs_req_valid, o_mbs_req_adr, o_mbs_req_wdata}, {1'b0, 18'h00104, 32'hA5A5_5A5A});
    end
  endtask

  task automatic test_read();
    int pulses = 0;
    int pulse_at = -1;
    int bad = 0;
    logic [31:0] got_data = '0;
    logic        got_err = 1'b1;
    drive_req(18'h00040, 1'b0, 32'h0, 4'hF);
    tick();
    i_req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_mbs_req_valid && (o_mbs_req_we !== 1'b0 || o_mbs_req_adr !== 18'h00040)) bad++;
      if (o_rsp_valid) begin
        pulses++; pulse_at = i; got_data = o_rsp_rdata; got_err = o_rsp_err;
      end
      i_mbs_resp_valid = (i >= 8 && i < 12);
      i_mbs_resp_rdata = i_mbs_resp_valid ? 32'hCAFE_F00D : 32'h0;
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL rd_fields: got %0d bad cycles expected 0", bad);
    end
    checks++;
    if (pulses !== 1) begin
      failures++; $display("FAIL rd_pulse_count: got %0d expected 1", pulses);
    end
    checks++;
    if (pulse_at !== 9) begin
      failures++; $display("FAIL rd_pulse_time: got %0d expected 9", pulse_at);
    end
    checks++;
    if ({got_data, got_err} !== {32'hCAFE_F00D, 1'b0}) begin
      failures++; $display("FAIL rd_data_err: got %h/%b expected cafef00d/0", got_data, got_err);
    end
  endtask

  task automatic test_read_then_write();
    int pulse_at = -1;
    int wr_rise = -1;
    logic [31:0] got_data = '0;
    drive_req(18'h00044, 1'b0, 32'h0, 4'hF);
    tick();
    drive_req(18'h00200, 1'b1, 32'hDEAD_BEEF, 4'h3);
    tick();
    i_req_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (o_rsp_valid) begin
        pulse_at = i; got_data = o_rsp_rdata;
      end
      if (o_mbs_req_valid && o_mbs_req_we && wr_rise < 0) wr_rise = i;
      i_mbs_resp_valid = (i >= 6 && i < 9);
      i_mbs_resp_rdata = i_mbs_resp_valid ? 32'h0BAD_F00D : 32'h0;
    end
    checks++;
    if (pulse_at !== 7 || got_data !== 32'h0BAD_F00D) begin
      failures++; $display("FAIL rw_rsp: got t=%0d data=%h expected t=7 data=0badf00d", pulse_at, got_data);
    end
    checks++;
    if (wr_rise !== 11) begin
      failures++; $display("FAIL rw_write_after_drain: got %0d expected 11", wr_rise);
    end
  endtask

  task automatic test_back_to_back();
    int ready_seen = 0;
    int early_wr = 0;
    int nrise = 0;
    int pulses = 0;
    bit fire;
    bit prev;
    int rise_at[5];
    logic [17:0] rise_adr[5];
    logic [31:0] rise_data[5];
    logic [31:0] got_data = '0;
    // Pending read keeps the sequencer busy so the writes fill the FIFO.
    drive_req(18'h00080, 1'b0, 32'h0, 4'hF);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive_req(18'h00100 + 18'(4 * k), 1'b1, 32'h1000_0000 + 32'(k), 4'hF);
      tick();
    end
    i_req_valid = 1'b0;
    checks++;
    if (o_req_ready !== 1'b0) begin
      failures++; $display("FAIL full_ready: got %b expected 0", o_req_ready);
    end
    drive_req(18'h00110, 1'b1, 32'h1000_0004, 4'hF);
    for (int i = 0; i < 6; i++) begin
      fire = i_req_valid && o_req_ready;
      tick();
      if (fire) i_req_valid = 1'b0;
      if (o_req_ready) ready_seen++;
      if (o_mbs_req_valid && o_mbs_req_we) early_wr++;
    end
    checks++;
    if (ready_seen !== 0 || i_req_valid !== 1'b1) begin
      failures++; $display("FAIL full_stall: got ready_cycles=%0d expected 0", ready_seen);
    end
    checks++;
    if (early_wr !== 0) begin
      failures++; $display("FAIL write_bypassed_read: got %0d cycles expected 0", early_wr);
    end
    prev = o_mbs_req_valid;
    for (int i = 0; i < 40; i++) begin
      fire = i_req_valid && o_req_ready;
      tick();
      if (fire) i_req_valid = 1'b0;
      if (o_mbs_req_valid && !prev && nrise < 5) begin
        rise_at[nrise] = i; rise_adr[nrise] = o_mbs_req_adr; rise_data[nrise] = o_mbs_req_wdata;
        nrise++;
      end
      prev = o_mbs_req_valid;
      if (o_rsp_valid) begin
        pulses++; got_data = o_rsp_rdata;
      end
      i_mbs_resp_valid = (i < 2);
      i_mbs_resp_rdata = i_mbs_resp_valid ? 32'h1234_5678 : 32'h0;
    end
    checks++;
    if (pulses !== 1 || got_data !== 32'h1234_5678) begin
      failures++; $display("FAIL b2b_read_rsp: got %0d pulses data=%h expected 1 / 12345678", pulses, got_data);
    end
    checks++;
    if (nrise !== 5) begin
      failures++; $display("FAIL b2b_count: got %0d expected 5", nrise);
    end
    for (int k = 0; k < nrise; k++) begin
      checks++;
      if (rise_at[k] !== 4 + 5 * k || rise_adr[k] !== 18'h00100 + 18'(4 * k) ||
          rise_data[k] !== 32'h1000_0000 + 32'(k)) begin
        failures++; $display("FAIL b2b_write%0d: got t=%0d adr=%h data=%h expected t=%0d adr=%h data=%h",
                             k, rise_at[k], rise_adr[k], rise_data[k],
                             4 + 5 * k, 18'h00100 + 18'(4 * k), 32'h1000_0000 + 32'(k));
      end
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    int blocked = 0;
    logic [31:0] got_data = '0;
    drive_req(18'h00090, 1'b0, 32'h0, 4'hF);
    tick();
    i_req_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (o_mbs_req_valid !== 1'b1) begin
      failures++; $display("FAIL mid_in_hold: got %b expected 1", o_mbs_req_valid);
    end
    rst_sram = 1'b1;
    tick();
    rst_sram = 1'b0;
    checks++;
    if ({o_mbs_req_valid, o_req_ready, o_rsp_valid, o_mbs_req_adr} !== 21'h0) begin
      failures++; $display("FAIL mid_reset_clear: got %h expected 0",
                           {o_mbs_req_valid, o_req_ready, o_rsp_valid, o_mbs_req_adr});
    end
    // Late response from the lost read.
    i_mbs_resp_valid = 1'b1;
    i_mbs_resp_rdata = 32'h5555_AAAA;
    tick();
    drive_req(18'h00094, 1'b0, 32'h0, 4'hF);
    tick();
    i_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (o_mbs_req_valid) blocked++;
      if (o_rsp_valid) pulses++;
    end
    checks++;
    if (blocked !== 0) begin
      failures++; $display("FAIL mid_read_gate: got %0d issue cycles expected 0", blocked);
    end
    i_mbs_resp_valid = 1'b0;
    i_mbs_resp_rdata = 32'h0;
    tick();
    checks++;
    if (o_mbs_req_valid !== 1'b1 || o_mbs_req_adr !== 18'h00094) begin
      failures++; $display("FAIL mid_read_issue: got %b/%h expected 1/00094", o_mbs_req_valid, o_mbs_req_adr);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (o_rsp_valid) begin
        pulses++; got_data = o_rsp_rdata;
      end
      i_mbs_resp_valid = (i >= 5 && i < 8);
      i_mbs_resp_rdata = i_mbs_resp_valid ? 32'h7777_0001 : 32'h0;
    end
    checks++;
    if (pulses !== 1 || got_data !== 32'h7777_0001) begin
      failures++; $display("FAIL mid_rsp: got %0d pulses data=%h expected 1 / 77770001", pulses, got_data);
    end
  endtask

`ifdef SRAM_PORT_TIMEOUT_EN
  task automatic test_timeout();
    int pulses = 0;
    int pulse_at = -1;
    int wr_rise = -1;
    logic [31:0] got_data = 32'hFFFF_FFFF;
    logic        got_err = 1'b0;
    drive_req(18'h000A0, 1'b0, 32'h0, 4'hF);
    tick();
    drive_req(18'h00300, 1'b1, 32'h0000_0003, 4'hF);
    tick();
    i_req_valid = 1'b0;
    for (int i = 0; i < 46; i++) begin
      tick();
      if (o_rsp_valid) begin
        pulses++; pulse_at = i; got_data = o_rsp_rdata; got_err = o_rsp_err;
      end
      if (o_mbs_req_valid && o_mbs_req_we && wr_rise < 0) wr_rise = i;
    end
    checks++;
    if (pulses !== 1 || pulse_at !== 35) begin
      failures++; $display("FAIL to_pulse: got %0d pulses at %0d expected 1 at 35", pulses, pulse_at);
    end
    checks++;
    if ({got_data, got_err} !== {32'h0, 1'b1}) begin
      failures++; $display("FAIL to_data_err: got %h/%b expected 00000000/1", got_data, got_err);
    end
    checks++;
    if (wr_rise !== 37) begin
      failures++; $display("FAIL to_next_req: got %0d expected 37", wr_rise);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_read();
    test_read_then_write();
    test_back_to_back();
    test_reset_mid();
`ifdef SRAM_PORT_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
